lc3b_fetch_stage: RTL

Instruction-fetch stage of the pipelined LC-3b. Owns the PC, runs the read/resp handshake with instruction memory, and drives the load/flush controls and data inputs of the downstream IF/ID state register. Handles downstream stalls by buffering one fetched word. Handles control-flow redirects, including a redirect that arrives while a memory read is still outstanding.

---
 rtl/lc3b_fetch_if.sv | 36 +++
 rtl/lc3b_fetch_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/lc3b_fetch_if.sv
// Bundle of the fetch stage's instruction-memory handshake, pipeline controls
// and IF/ID register data inputs.
interface lc3b_fetch_if #(
   parameter int width = 16
);
   logic             imem_read;
   logic [width-1:0] imem_address;
   logic             imem_resp;
   logic [width-1:0] imem_rdata;

   logic             stall;
   logic             redirect;
   logic [width-1:0] redirect_pc;

   logic             ifid_load;
   logic             ifid_flush;
   logic [width-1:0] ifid_pc;
   logic [width-1:0] ifid_pc_plus2;
   logic [width-1:0] ifid_ir;

   // The fetch stage drives requests and IF/ID inputs.
   modport master (
      output imem_read, imem_address,
      output ifid_load, ifid_flush, ifid_pc, ifid_pc_plus2, ifid_ir,
      input  imem_resp, imem_rdata,
      input  stall, redirect, redirect_pc
   );

   // Memory and pipeline control see the mirror image.
   modport slave (
      input  imem_read, imem_address,
      input  ifid_load, ifid_flush, ifid_pc, ifid_pc_plus2, ifid_ir,
      output imem_resp, imem_rdata,
      output stall, redirect, redirect_pc
   );
endinterface

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, handshakes with instruction memory,
// buffers one word under stall and cleanly abandons fetches on redirect.
module lc3b_fetch_stage #(
   parameter int               width    = 16,
   parameter logic [width-1:0] reset_pc = '0
) (
   input  logic         clk,
   input  logic         reset,
   lc3b_fetch_if.master bus
);

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DISCARD
   } state_e;

   localparam logic [width-1:0] pc_step = width'(2);

   state_e           state_q, state_d;
   logic [width-1:0] pc_q, pc_d;
   logic [width-1:0] pending_q, pending_d;
   logic [width-1:0] buf_q, buf_d;
   logic [width-1:0] target_pc;

   // Instructions are halfword aligned, so the low bit of a target is ignored.
   assign target_pc = bus.redirect_pc & ~width'(1);

   // NOTE: sequential state is updated only with non-blocking assignments so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= reset_pc;
         pending_q <= '0;
         // NOTE: the one-word buffer is an ordinary register, so it is cleared with
         // the rest of the state rather than left as uninitialised storage.
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         buf_q     <= buf_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d          = state_q;
      pc_d             = pc_q;
      pending_d        = pending_q;
      buf_d            = buf_q;
      bus.imem_read    = 1'b0;
      bus.imem_address = pc_q;
      bus.ifid_load    = 1'b0;
      bus.ifid_ir      = bus.imem_rdata;
      bus.ifid_pc      = pc_q;

      unique case (state_q)
         FETCH: begin
            bus.imem_read = 1'b1;
            if (bus.imem_resp) begin
               if (bus.redirect) begin
                  pc_d = target_pc;
               end else if (bus.stall) begin
                  buf_d   = bus.imem_rdata;
                  state_d = HOLD;
               end else begin
                  bus.ifid_load = 1'b1;
                  pc_d          = pc_q + pc_step;
               end
            end else if (bus.redirect) begin
               // The read of pc_q is still outstanding; remember where to go next.
               pending_d = target_pc;
               state_d   = DISCARD;
            end
         end

         HOLD: begin
            bus.ifid_ir = buf_q;
            if (bus.redirect) begin
               pc_d    = target_pc;
               state_d = FETCH;
            end else if (!bus.stall) begin
               bus.ifid_load = 1'b1;
               pc_d          = pc_q + pc_step;
               state_d       = FETCH;
            end
         end

         DISCARD: begin
            // Address stays at the abandoned pc until memory answers.
            bus.imem_read = 1'b1;
            if (bus.redirect) begin
               pending_d = target_pc;
            end
            if (bus.imem_resp) begin
               pc_d    = bus.redirect ? target_pc : pending_q;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   assign bus.ifid_flush    = bus.redirect;
   assign bus.ifid_pc_plus2 = bus.ifid_pc + pc_step;

endmodule
